booth24f_mul_arbiter: RTL and testbench
=======================================

Name: booth24f_mul_arbiter

Overview:
- Shares one combinational booth24f 24-bit fixed-point multiplier (Q2.22 operands/result) between NREQ requesters.
- Round-robin arbitration, valid/ready on both request and response sides.
- Operands are registered; the multiplier output is captured after a programmable multicycle wait, so booth24f's long combinational path is never timed as single-cycle.
- Sits between the filter/datapath engines and the single booth24f instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of rsp_id; must satisfy 2**IDW >= NREQ.
- MUL_CYCLES, 2, clock cycles allowed for booth24f to settle (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  NREQ  per-requester operation request.
- req_a  input  NREQ*24  operand A, requester i in bits [24i+23:24i].
- req_b  input  NREQ*24  operand B, same packing.
- req_ready  output  NREQ  one-hot grant/accept strobe.
- mul_a  output  24  registered operand A to booth24f input a.
- mul_b  output  24  registered operand B to booth24f input b.
- mul_s  input  24  booth24f product s.
- rsp_valid  output  1  result available.
- rsp_data  output  24  captured product.
- rsp_id  output  IDW  index of the requester that owns rsp_data.
- rsp_ready  input  1  consumer accepts the result.
- busy  output  1  high in WAIT or RESP.

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE; mul_a=mul_b=0; rsp_valid=0; rsp_data=0; rsp_id=0; busy=0; cnt=0; rr_ptr=NREQ-1, so requester 0 has first priority.
- req_ready is combinational and is zero outside IDLE and on rst_n low.
- Requesters hold req_valid and operands stable until accepted. Dropping req_valid before acceptance is permitted; the request is then simply not granted.
- Arbitration (IDLE only): the winner is the first i with req_valid[i] scanning rr_ptr+1, rr_ptr+2, ... modulo NREQ. req_ready[winner]=1 in the same cycle; all other bits are 0.
- Accept edge (IDLE with any req_valid):
  - mul_a/mul_b <= winner operands.
  - rsp_id <= winner.
  - rr_ptr <= winner.
  - cnt <= MUL_CYCLES-1.
  - state <= WAIT.
- IDLE with no req_valid: everything holds.
- WAIT:
  - If cnt!=0, cnt decrements.
  - If cnt==0: rsp_data <= mul_s, rsp_valid <= 1, state <= RESP.
  - rsp_valid therefore rises exactly MUL_CYCLES cycles after the accept edge.
- RESP:
  - rsp_valid, rsp_data and rsp_id are held stable until rsp_ready.
  - On rsp_valid&rsp_ready: rsp_valid <= 0, state <= IDLE.
  - No new grant in the handshake cycle; the next grant is possible in the following IDLE cycle.
- Peak throughput: one operation per MUL_CYCLES+2 cycles.
- mul_a/mul_b change only at an accept edge or reset; they hold during WAIT, RESP and IDLE.
- rsp_data/rsp_id retain their last values after the handshake.
- busy = (state != IDLE).
- No arithmetic is done in this block. rsp_data is mul_s bit-for-bit; overflow/truncation semantics belong to booth24f.
- Reset mid-operation (WAIT or RESP): the in-flight result is discarded, all reset values apply, and no rsp_valid is produced.
- Illegal state encoding: return to IDLE.

Test Plan:
- Single request: req0 a=0x400000, b=0x400000 (1.0*1.0), rsp_ready=1, MUL_CYCLES=2 → req_ready[0] for one cycle; rsp_valid 2 cycles after accept; rsp_data=0x400000; rsp_id=0; busy low the cycle after handshake.
- Round robin: all four requesters valid continuously, operands 0x200000*0x600000 (0.5*1.5) → grants 0,1,2,3,0 in order; every rsp_data=0x300000; rsp_id sequence 0,1,2,3,0; 4-cycle spacing between grants.
- Backpressure: rsp_ready low for 10 cycles after rsp_valid, with req1 pending → rsp_valid/rsp_data/rsp_id stable; req_ready stays 0; req1 granted only after the handshake plus one IDLE cycle.
- Operand stability: a requester changes req_a after acceptance → mul_a unchanged until the next accept; rsp_data equals the product of the originally accepted operands.
- Reset mid-op: rst_n low during WAIT → next cycle all outputs at reset values; no rsp_valid; first request after reset goes to requester 0 when requesters 0 and 3 both request.
- MUL_CYCLES=1 build: req2 a=0x4E4C2F, b=0x788B43 → rsp_valid 1 cycle after accept; rsp_data equals the booth24f model output for those operands; rsp_id=2.

Source files
------------

// File: rtl/booth24f_mul_arbiter.sv
// Purpose: round-robin arbiter that shares one combinational booth24f Q2.22 multiplier between NREQ requesters.
// Latency: rsp_valid rises MUL_CYCLES cycles after the accept edge; peak rate is one op per MUL_CYCLES+2 cycles.
// Backpressure: rsp_valid/rsp_data/rsp_id hold until rsp_ready; req_ready stays low whenever the block is not IDLE.
module booth24f_mul_arbiter #(
    parameter int NREQ       = 4,
    parameter int IDW        = 2,
    parameter int MUL_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*24-1:0]   req_a,
    input  logic [NREQ*24-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [23:0]          mul_a,
    output logic [23:0]          mul_b,
    input  logic [23:0]          mul_s,
    output logic                 rsp_valid,
    output logic [23:0]          rsp_data,
    output logic [IDW-1:0]       rsp_id,
    input  logic                 rsp_ready,
    output logic                 busy
);

    // Counter only has to hold MUL_CYCLES-1.
    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [IDW-1:0]  rr_ptr;

    logic            any_vld;
    logic [IDW-1:0]  win;
    logic [23:0]     win_a;
    logic [23:0]     win_b;

    // Round-robin pick: first valid requester scanning from rr_ptr+1, wrapping modulo NREQ.
    always_comb begin
        int idx;
        any_vld = 1'b0;
        win     = '0;
        idx     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!any_vld && (idx == i) && req_valid[i]) begin
                    any_vld = 1'b1;
                    win     = IDW'(i);
                end
            end
        end
    end

    // Winner operand mux and one-hot grant; grant is suppressed outside IDLE and while reset is asserted.
    always_comb begin
        win_a     = '0;
        win_b     = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                win_a = req_a[i*24 +: 24];
                win_b = req_b[i*24 +: 24];
                if (rst_n && (state == IDLE) && any_vld) begin
                    req_ready[i] = 1'b1;
                end
            end
        end
    end

    assign busy = (state != IDLE);

    // Control FSM: accept in IDLE, let the multiplier settle in WAIT, hold the result in RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rr_ptr    <= IDW'(NREQ - 1);
            mul_a     <= '0;
            mul_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_vld) begin
                        mul_a  <= win_a;
                        mul_b  <= win_b;
                        rsp_id <= win;
                        rr_ptr <= win;
                        cnt    <= CW'(MUL_CYCLES - 1);
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        rsp_data  <= mul_s;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth24f_mul_arbiter.sv
// Purpose: directed self-checking bench for booth24f_mul_arbiter (MUL_CYCLES=2 and MUL_CYCLES=1 instances).
// Latency: checks grant timing, rsp_valid delay after accept and round-robin spacing cycle by cycle.
// Backpressure: holds rsp_ready low for ten cycles and checks response stability and grant suppression.
module tb_booth24f_mul_arbiter;

    logic        clk;
    logic        rst_n;

    // Instance 0: MUL_CYCLES = 2
    logic [3:0]  req_valid;
    logic [95:0] req_a;
    logic [95:0] req_b;
    logic [3:0]  req_ready;
    logic [23:0] mul_a;
    logic [23:0] mul_b;
    logic [23:0] mul_s;
    logic        rsp_valid;
    logic [23:0] rsp_data;
    logic [1:0]  rsp_id;
    logic        rsp_ready;
    logic        busy;

    // Instance 1: MUL_CYCLES = 1
    logic [3:0]  req_valid1;
    logic [95:0] req_a1;
    logic [95:0] req_b1;
    logic [3:0]  req_ready1;
    logic [23:0] mul_a1;
    logic [23:0] mul_b1;
    logic [23:0] mul_s1;
    logic        rsp_valid1;
    logic [23:0] rsp_data1;
    logic [1:0]  rsp_id1;
    logic        rsp_ready1;
    logic        busy1;

    int checks = 0;
    int errors = 0;

    // Reference booth24f: signed Q2.22 x Q2.22, keep product bits [45:22].
    function automatic logic [23:0] booth_model(input logic [23:0] a, input logic [23:0] b);
        logic signed [47:0] sa;
        logic signed [47:0] sb;
        logic signed [47:0] p;
        sa = {{24{a[23]}}, a};
        sb = {{24{b[23]}}, b};
        p  = sa * sb;
        return p[45:22];
    endfunction

    assign mul_s  = booth_model(mul_a, mul_b);
    assign mul_s1 = booth_model(mul_a1, mul_b1);

    booth24f_mul_arbiter #(.NREQ(4), .IDW(2), .MUL_CYCLES(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_s     (mul_s),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    booth24f_mul_arbiter #(.NREQ(4), .IDW(2), .MUL_CYCLES(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid1),
        .req_a     (req_a1),
        .req_b     (req_b1),
        .req_ready (req_ready1),
        .mul_a     (mul_a1),
        .mul_b     (mul_b1),
        .mul_s     (mul_s1),
        .rsp_valid (rsp_valid1),
        .rsp_data  (rsp_data1),
        .rsp_id    (rsp_id1),
        .rsp_ready (rsp_ready1),
        .busy      (busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 4'b0001;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 1'b0;
        req_valid1 = '0;
        req_a1     = '0;
        req_b1     = '0;
        rsp_ready1 = 1'b0;
        cyc();
        cyc();
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_mul_a",     32'(mul_a),     32'h0);
        chk("rst_rsp_data",  32'(rsp_data),  32'h0);
        chk("rst_rsp_id",    32'(rsp_id),    32'h0);

        // Single request: 1.0 * 1.0
        rst_n     = 1'b1;
        req_valid = 4'b0001;
        req_a[0 +: 24] = 24'h400000;
        req_b[0 +: 24] = 24'h400000;
        rsp_ready = 1'b1;
        #1;
        chk("t1_grant", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 4'b0000;
        #1;
        chk("t1_ready_wait", 32'(req_ready), 32'h0);
        chk("t1_busy_wait",  32'(busy),      32'h1);
        chk("t1_mul_a",      32'(mul_a),     32'h400000);
        chk("t1_mul_b",      32'(mul_b),     32'h400000);
        chk("t1_vld_e0",     32'(rsp_valid), 32'h0);
        cyc();
        chk("t1_vld_e1",     32'(rsp_valid), 32'h0);
        cyc();
        chk("t1_vld_e2",     32'(rsp_valid), 32'h1);
        chk("t1_data",       32'(rsp_data),  32'h400000);
        chk("t1_id",         32'(rsp_id),    32'h0);
        cyc();
        chk("t1_busy_after", 32'(busy),      32'h0);
        chk("t1_vld_after",  32'(rsp_valid), 32'h0);
        chk("t1_data_keep",  32'(rsp_data),  32'h400000);

        // Round robin: 0.5 * 1.5 from all four requesters continuously
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_a[i*24 +: 24] = 24'h200000;
            req_b[i*24 +: 24] = 24'h600000;
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            chk("rr_grant", 32'(req_ready), 32'h1 << (g % 4));
            cyc();
            chk("rr_ready_c1", 32'(req_ready), 32'h0);
            cyc();
            chk("rr_ready_c2", 32'(req_ready), 32'h0);
            cyc();
            chk("rr_vld",  32'(rsp_valid), 32'h1);
            chk("rr_data", 32'(rsp_data),  32'h300000);
            chk("rr_id",   32'(rsp_id),    32'(g % 4));
            cyc();
            #1;
        end
        req_valid = 4'b0000;

        // Backpressure with req1 pending, then operand stability on req1
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        req_valid = 4'b0001;
        req_a[0 +: 24] = 24'h400000;
        req_b[0 +: 24] = 24'h200000;
        rsp_ready = 1'b0;
        #1;
        chk("bp_grant0", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 4'b0010;
        req_a[24 +: 24] = 24'h100000;
        req_b[24 +: 24] = 24'h400000;
        #1;
        chk("bp_ready_wait", 32'(req_ready), 32'h0);
        cyc();
        cyc();
        for (int i = 0; i < 10; i++) begin
            chk("bp_vld",   32'(rsp_valid), 32'h1);
            chk("bp_data",  32'(rsp_data),  32'h200000);
            chk("bp_id",    32'(rsp_id),    32'h0);
            chk("bp_ready", 32'(req_ready), 32'h0);
            cyc();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_ready_hs", 32'(req_ready), 32'h0);
        cyc();
        chk("bp_vld_low",   32'(rsp_valid), 32'h0);
        chk("bp_grant1",    32'(req_ready), 32'h2);
        chk("bp_data_keep", 32'(rsp_data),  32'h200000);
        cyc();
        req_a[24 +: 24] = 24'h7FFFFF;
        req_valid = 4'b0000;
        #1;
        chk("os_mul_a_e0", 32'(mul_a), 32'h100000);
        chk("os_ready",    32'(req_ready), 32'h0);
        cyc();
        chk("os_mul_a_e1", 32'(mul_a), 32'h100000);
        cyc();
        chk("os_vld",  32'(rsp_valid), 32'h1);
        chk("os_data", 32'(rsp_data),  32'h100000);
        chk("os_id",   32'(rsp_id),    32'h1);
        cyc();
        chk("os_mul_a_idle", 32'(mul_a), 32'h100000);
        chk("os_busy_idle",  32'(busy),  32'h0);

        // Reset mid-operation (req3 in WAIT), then req0 and req3 compete
        req_valid = 4'b1000;
        req_a[72 +: 24] = 24'h400000;
        req_b[72 +: 24] = 24'h400000;
        #1;
        chk("mr_grant3", 32'(req_ready), 32'h8);
        cyc();
        chk("mr_busy_wait", 32'(busy), 32'h1);
        rst_n = 1'b0;
        req_valid = 4'b1001;
        #1;
        chk("mr_ready_rst", 32'(req_ready), 32'h0);
        cyc();
        chk("mr_vld",   32'(rsp_valid), 32'h0);
        chk("mr_busy",  32'(busy),      32'h0);
        chk("mr_mul_a", 32'(mul_a),     32'h0);
        chk("mr_mul_b", 32'(mul_b),     32'h0);
        chk("mr_data",  32'(rsp_data),  32'h0);
        chk("mr_id",    32'(rsp_id),    32'h0);
        rst_n = 1'b1;
        req_a[0 +: 24] = 24'h200000;
        req_b[0 +: 24] = 24'h200000;
        #1;
        chk("mr_grant0", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 4'b0000;
        #1;
        chk("mr_id_acc",    32'(rsp_id), 32'h0);
        chk("mr_mul_a_acc", 32'(mul_a),  32'h200000);
        cyc();
        chk("mr_vld_e1", 32'(rsp_valid), 32'h0);
        cyc();
        chk("mr_vld_new",  32'(rsp_valid), 32'h1);
        chk("mr_data_new", 32'(rsp_data),  32'h100000);
        chk("mr_id_new",   32'(rsp_id),    32'h0);
        cyc();

        // MUL_CYCLES=1 instance: req2 a=0x4E4C2F, b=0x788B43
        req_valid1 = 4'b0100;
        req_a1[48 +: 24] = 24'h4E4C2F;
        req_b1[48 +: 24] = 24'h788B43;
        rsp_ready1 = 1'b1;
        #1;
        chk("m1_grant2", 32'(req_ready1), 32'h4);
        cyc();
        req_valid1 = 4'b0000;
        #1;
        chk("m1_vld_e0",  32'(rsp_valid1), 32'h0);
        chk("m1_busy_e0", 32'(busy1),      32'h1);
        cyc();
        chk("m1_vld_e1", 32'(rsp_valid1), 32'h1);
        chk("m1_data",   32'(rsp_data1),  32'h937937);
        chk("m1_id",     32'(rsp_id1),    32'h2);
        cyc();
        chk("m1_busy_after", 32'(busy1), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
